// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, legality check and the op-driver FSM states.
// Every block talking to the 32-bit ALU imports this so opcodes stay consistent.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } alu_state_e;

  function automatic logic alu_op_legal(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_op_driver_if.sv
// Bundle of request, ALU-drive and response signals around alu_op_driver.
// slave = the driver block; master = requester plus the combinational ALU it drives.
interface alu_op_driver_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);

  // Handshakes (req_* and rsp_*): a transfer happens on a rising edge where valid and
  // ready are both 1; once valid is raised the payload is held until that transfer.
  logic                     req_valid;
  logic                     req_ready;
  logic [WIDTH-1:0]         req_a;
  logic [WIDTH-1:0]         req_b;
  logic [2:0]               req_op;

  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [2:0]               alu_op;
  logic [WIDTH-1:0]         alu_result;
  logic                     alu_zero;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_zero;
  logic                     rsp_err;

  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, rsp_err, count
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero, rsp_err, count
  );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; head shows the oldest entry whenever empty is low.
// Pushes into a full FIFO and pops from an empty one are ignored.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 67
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_op_driver.sv
// Queues ALU requests, drives the shared combinational ALU one request at a time and
// returns each captured result in request order over the response handshake.
module alu_op_driver
  import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_op_driver_if.slave bus,
    output alu_state_e     fsm_state
);

  localparam int DW = 2 * WIDTH + 3;

  alu_state_e       state_q;
  logic             err_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             load;
  logic [DW-1:0]    head;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [2:0]       head_op;

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.req_valid),
    .pop     (load),
    .din     ({bus.req_a, bus.req_b, bus.req_op}),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (bus.count)
  );

  assign head_a        = head[DW-1 -: WIDTH];
  assign head_b        = head[WIDTH+2 -: WIDTH];
  assign head_op       = head[2:0];
  assign bus.req_ready = !fifo_full;
  assign fsm_state     = state_q;

  // The head is taken either from IDLE or on the edge that retires the current response.
  assign load = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      err_q          <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= ALU_AND;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) state_q <= ST_DRIVE;
        end
        ST_DRIVE: begin
          bus.rsp_valid  <= 1'b1;
          bus.rsp_result <= err_q ? '0 : bus.alu_result;
          bus.rsp_zero   <= err_q ? 1'b1 : bus.alu_zero;
          bus.rsp_err    <= err_q;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state_q       <= load ? ST_DRIVE : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Illegal opcodes still present their operands, but the ALU sees a harmless AND.
      if (load) begin
        bus.alu_a  <= head_a;
        bus.alu_b  <= head_b;
        bus.alu_op <= alu_op_legal(head_op) ? head_op : ALU_AND;
        err_q      <= !alu_op_legal(head_op);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: directed scenarios plus a randomized phase, with a queue
// scoreboard fed at request acceptance and drained by a response monitor.
module tb_alu_op_driver;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic       clk;
  logic       reset_n;
  alu_state_e fsm_state;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  logic [WIDTH+1:0] exp_q[$];
  int               rsp_cyc[$];

  alu_op_driver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  alu_op_driver #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // ---------------- ALU stand-in and reference ----------------
  function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a, b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_zero   = (bus.alu_result == '0);

  function automatic logic op_ok(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  endfunction

  // Expected response word {err, zero, result}.
  function automatic logic [WIDTH+1:0] ref_rsp(input logic [WIDTH-1:0] a, b, input logic [2:0] op);
    logic [WIDTH-1:0] r;
    if (!op_ok(op)) return {2'b11, {WIDTH{1'b0}}};
    r = alu_model(a, b, op);
    return {1'b0, (r == '0), r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [WIDTH-1:0] a, b, input logic [2:0] op);
    int waited = 0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      waited++;
      if (waited > 200) begin
        chk("push_timeout", 64'(waited), 64'(0));
        bus.req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    exp_q.push_back(ref_rsp(a, b, op));
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) return;
    end
    chk(name, 64'(bus.rsp_valid), 64'(1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_valid) break;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_count"},      64'(bus.count),      64'(0));
    chk({tag, "_req_ready"},  64'(bus.req_ready),  64'(1));
    chk({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'(0));
    chk({tag, "_rsp_result"}, 64'(bus.rsp_result), 64'(0));
    chk({tag, "_rsp_flags"},  64'({bus.rsp_zero, bus.rsp_err}), 64'(0));
    chk({tag, "_alu_ab"},     {bus.alu_a, bus.alu_b}, 64'(0));
    chk({tag, "_alu_op"},     64'(bus.alu_op),     64'(0));
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic             prev_ok = 1'b0;
  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [WIDTH+2:0] prev_rsp = '0;
  logic [2*WIDTH+2:0] prev_alu = '0;

  always @(negedge clk) begin
    logic [WIDTH+1:0]   got;
    logic [2*WIDTH+2:0] alu_now;
    got     = {bus.rsp_err, bus.rsp_zero, bus.rsp_result};
    alu_now = {bus.alu_a, bus.alu_b, bus.alu_op};
    if (reset_n) begin
      chk("req_ready_vs_count", 64'(bus.req_ready), 64'(bus.count != CW'(DEPTH)));
      chk("alu_op_legal", 64'(op_ok(bus.alu_op)), 64'(1));
      if (bus.rsp_valid) chk("state_resp", 64'(fsm_state == ST_RESP), 64'(1));
      if (prev_ok && prev_valid && !prev_ready)
        chk("rsp_stable", 64'({bus.rsp_valid, got}), 64'(prev_rsp));
      if (prev_ok && alu_now != prev_alu && bus.rsp_valid)
        chk("alu_stable", alu_now[63:0], prev_alu[63:0]);
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got %h expected no response", got);
        end else begin
          chk("rsp_data", 64'(got), 64'(exp_q.pop_front()));
        end
      end
    end
    prev_ok    = reset_n;
    prev_valid = bus.rsp_valid;
    prev_ready = bus.rsp_ready;
    prev_rsp   = {bus.rsp_valid, got};
    prev_alu   = alu_now;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [2:0]       rop;
    logic             saw_valid;
    bit               rand_done;

    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_cleared("reset");

    // 1: single AND with latency check
    @(posedge clk); #1;
    push_req(32'hFFFF0000, 32'h0000FFFF, ALU_AND);
    @(negedge clk) chk("lat_after_e0", 64'(bus.rsp_valid), 64'(0));
    @(negedge clk) chk("lat_after_e1", 64'(bus.rsp_valid), 64'(0));
    chk("lat_alu_a", 64'(bus.alu_a), 64'(32'hFFFF0000));
    @(negedge clk) chk("lat_after_e2", 64'(bus.rsp_valid), 64'(1));
    wait_drain();

    // 2: back-to-back OR, ADD, SUB
    @(posedge clk); #1;
    rsp_cyc.delete();
    push_req(32'hFFFF0000, 32'h0000FFFF, ALU_OR);
    push_req(32'hFFFF0000, 32'h0000FFFF, ALU_ADD);
    push_req(32'h0000FFFF, 32'h0000FFFF, ALU_SUB);
    wait_drain();
    chk("b2b_count", 64'(rsp_cyc.size()), 64'(3));
    if (rsp_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(rsp_cyc[1] - rsp_cyc[0]), 64'(2));
      chk("b2b_gap2", 64'(rsp_cyc[2] - rsp_cyc[1]), 64'(2));
    end

    // 3: backpressure, five requests then full
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_req($urandom, $urandom, ALU_ADD);
    push_req(32'h0000FFFF, 32'h0F0FF0F0, ALU_XOR);
    @(negedge clk);
    chk("bp_count_full", 64'(bus.count), 64'(DEPTH));
    chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    repeat (4) @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    push_req(32'h12345678, 32'h12345678, ALU_SUB);
    wait_drain();

    // 4: illegal opcode between legal ones
    @(posedge clk); #1;
    push_req(32'h00000005, 32'h00000007, ALU_ADD);
    push_req(32'hDEADBEEF, 32'h00000000, 3'b101);
    push_req(32'h00000009, 32'h00000004, ALU_SUB);
    wait_drain();

    // 5: reset while a response is pending with two entries queued
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_req($urandom, $urandom, ALU_OR);
    wait_rsp_valid("rst_wait_valid");
    chk("rst_pre_count", 64'(bus.count), 64'(2));
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_cleared("midreset");
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (10) @(negedge clk) saw_valid |= bus.rsp_valid;
    chk("rst_no_stale", 64'(saw_valid), 64'(0));

    // 6: push and pop together at DEPTH-1, across pointer wrap
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_req($urandom, $urandom, ALU_XOR);
    @(negedge clk);
    chk("pp_start_count", 64'(bus.count), 64'(DEPTH - 1));
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      bus.rsp_ready = 1'b1;
      push_req($urandom, $urandom, 3'($urandom_range(0, 7)));
      bus.rsp_ready = 1'b0;
      @(negedge clk) chk("pp_count_hold", 64'(bus.count), 64'(DEPTH - 1));
      wait_rsp_valid("pp_wait_valid");
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    wait_drain();

    // Randomized phase with random consumer backpressure
    @(posedge clk); #1;
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          ra  = $urandom;
          rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
          rop = 3'($urandom_range(0, 7));
          push_req(ra, rb, rop);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
